// File: rtl/ahbl_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahbl_apb_bridge
//
// AHB-Lite slave to APB3 master bridge. Each AHB-Lite single transfer becomes
// one APB SETUP/ACCESS sequence. The bridge inserts wait states on HREADYOUT
// while the APB side is busy. It decodes one of sixteen PSEL lines from a
// 4-bit field of HADDR. PSLVERR, an optional PREADY timeout and illegal
// (non-word) writes all produce the two-cycle AHB ERROR response.
//
// Parameters
//   SEL_LSB   lowest HADDR bit of the 4-bit PSEL index field (2..28)
//   TIMEOUT   maximum ACCESS cycles with PREADY low, 0 = no timeout (<=65535)
//
// Ports
//   HCLK, HRESET        clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN
//                       AHB-Lite slave request side
//   HREADYOUT, HRESP, HRDATA
//                       AHB-Lite slave response side (all registered)
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA
//                       APB3 master request side (all registered)
//   PRDATA, PREADY, PSLVERR
//                       APB3 completer response
// ---------------------------------------------------------------------------
module ahbl_apb_bridge #(
    parameter int SEL_LSB = 24,
    parameter int TIMEOUT = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] PADDR,
    output logic [15:0] PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    // Counter value seen in the last ACCESS cycle allowed before timing out.
    localparam logic [15:0] TIMEOUT_LAST =
        (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  sel_idx;
    logic [3:0]  sel_idx_next;
    logic [15:0] timeout_cnt;
    logic        cap;
    logic        capture_now;
    logic        timed_out;

    // HTRANS[0] only distinguishes SEQ from NONSEQ (or BUSY from IDLE);
    // single transfers treat both alike.
    logic        unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // Next-state decode. A new address phase is accepted only when the bridge
    // is showing HREADYOUT high, i.e. in IDLE or in the second ERROR cycle,
    // which lets a master pipeline its next request into a completing cycle.
    always_comb begin
        next_state   = state;
        cap          = HSEL & HTRANS[1] & HREADYIN & HREADYOUT;
        capture_now  = 1'b0;
        timed_out    = 1'b0;
        sel_idx_next = sel_idx;

        if (TIMEOUT != 0) begin
            timed_out = (timeout_cnt == TIMEOUT_LAST);
        end

        case (state)
            IDLE, ERR2: begin
                if (cap) begin
                    capture_now  = 1'b1;
                    sel_idx_next = HADDR[SEL_LSB +: 4];
                    if (HWRITE && (HSIZE != 3'b010)) begin
                        next_state = ERR1;
                    end else if (HWRITE) begin
                        next_state = LATCH;
                    end else begin
                        next_state = SETUP;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            LATCH: begin
                next_state = SETUP;
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    next_state = PSLVERR ? ERR1 : IDLE;
                end else if (timed_out) begin
                    next_state = ERR1;
                end
            end
            ERR1: begin
                next_state = ERR2;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Response and APB control outputs are registered from the next state so
    // that every output is a flop yet still lines up with the state it
    // belongs to.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            PSEL      <= 16'h0000;
            PENABLE   <= 1'b0;
        end else begin
            HREADYOUT <= (next_state == IDLE) || (next_state == ERR2);
            HRESP     <= (next_state == ERR1) || (next_state == ERR2);
            PENABLE   <= (next_state == ACCESS);
            if ((next_state == SETUP) || (next_state == ACCESS)) begin
                PSEL <= 16'h0001 << sel_idx_next;
            end else begin
                PSEL <= 16'h0000;
            end
        end
    end

    // Address-phase capture. Illegal writes are captured as well; they simply
    // never reach SETUP, so PADDR/PWRITE change without any APB activity.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            PADDR   <= 32'h0;
            PWRITE  <= 1'b0;
            sel_idx <= 4'h0;
        end else if (capture_now) begin
            PADDR   <= HADDR;
            PWRITE  <= HWRITE;
            sel_idx <= sel_idx_next;
        end
    end

    // Write data is only valid in the AHB data phase, which is the LATCH cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            PWDATA <= 32'h0;
        end else if (state == LATCH) begin
            PWDATA <= HWDATA;
        end
    end

    // Read data is taken only from a successful read completion and held
    // until the next one.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HRDATA <= 32'h0;
        end else if ((state == ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
            HRDATA <= PRDATA;
        end
    end

    // Counts ACCESS cycles with PREADY low; restarted for every APB transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            timeout_cnt <= 16'h0;
        end else if (next_state == SETUP) begin
            timeout_cnt <= 16'h0;
        end else if ((state == ACCESS) && !PREADY) begin
            timeout_cnt <= timeout_cnt + 16'h1;
        end
    end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahbl_apb_bridge
//
// Directed self-checking bench for ahbl_apb_bridge (SEL_LSB=24, TIMEOUT=4).
// Plays an AHB-Lite master and a simple APB completer whose wait states and
// error response are chosen per transfer. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_ahbl_apb_bridge;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] PADDR;
    logic [15:0] PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int compared;
    int mismatched;

    int          lowCycles;
    int          accCycles;
    int          errCycles;
    logic [15:0] pselSeen;

    ahbl_apb_bridge #(
        .SEL_LSB (24),
        .TIMEOUT (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // 10 time-unit clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Last-resort guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=no-finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Present an AHB address phase (NONSEQ) for the current cycle.
    task automatic applyStimulus(input logic write, input logic [31:0] addr,
                                 input logic [2:0] size);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = write;
        HADDR  = addr;
        HSIZE  = size;
    endtask

    task automatic endAddressPhase();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
    endtask

    // One complete transfer: address phase, data phase, APB completer
    // inserting waitReq low-PREADY ACCESS cycles, then PREADY with PSLVERR=errReq.
    // Returns in the first cycle with HREADYOUT high (bounded at 50 cycles).
    task automatic runTransfer(input logic write, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               input int waitReq, input logic errReq,
                               input logic [31:0] rdata);
        lowCycles = 0;
        accCycles = 0;
        errCycles = 0;
        pselSeen  = 16'h0;
        applyStimulus(write, addr, size);
        tick();
        endAddressPhase();
        HWDATA = wdata;
        while (!HREADYOUT && lowCycles < 50) begin
            pselSeen = pselSeen | PSEL;
            if (HRESP) errCycles++;
            if (PENABLE) begin
                if (accCycles < waitReq) begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'b0;
                end else begin
                    PREADY  = 1'b1;
                    PSLVERR = errReq;
                    PRDATA  = rdata;
                end
                accCycles++;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
            tick();
            lowCycles++;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        HRESET   = 1'b1;
        HREADYIN = 1'b1;
        HWDATA   = 32'h0;
        HADDR    = 32'h0;
        PRDATA   = 32'h0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        endAddressPhase();
        repeat (3) @(posedge HCLK);
        #3;
        HRESET = 1'b0;
        tick();

        // Reset state
        checkOutput("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        checkOutput("rst_hresp",     32'(HRESP),     32'd0);
        checkOutput("rst_hrdata",    HRDATA,         32'h0);
        checkOutput("rst_paddr",     PADDR,          32'h0);
        checkOutput("rst_pwdata",    PWDATA,         32'h0);
        checkOutput("rst_psel",      32'(PSEL),      32'h0);
        checkOutput("rst_penable",   32'(PENABLE),   32'd0);
        checkOutput("rst_pwrite",    32'(PWRITE),    32'd0);

        // Word write, no wait: 3 wait states, PSEL[3]
        runTransfer(1'b1, 32'h0300_0010, 3'b010, 32'hA5A5_0001, 0, 1'b0, 32'h0);
        checkOutput("wr_low_cycles", 32'(lowCycles), 32'd3);
        checkOutput("wr_acc_cycles", 32'(accCycles), 32'd1);
        checkOutput("wr_psel",       32'(pselSeen),  32'h0008);
        checkOutput("wr_hresp",      32'(HRESP),     32'd0);
        checkOutput("wr_paddr",      PADDR,          32'h0300_0010);
        checkOutput("wr_pwdata",     PWDATA,         32'hA5A5_0001);
        checkOutput("wr_pwrite",     32'(PWRITE),    32'd1);
        checkOutput("wr_psel_after", 32'(PSEL),      32'h0);

        // Read with two PREADY-low ACCESS cycles: 4 wait states, PSEL[1]
        runTransfer(1'b0, 32'h0100_0004, 3'b010, 32'h0, 2, 1'b0, 32'h1234_5678);
        checkOutput("rd_low_cycles", 32'(lowCycles), 32'd4);
        checkOutput("rd_acc_cycles", 32'(accCycles), 32'd3);
        checkOutput("rd_psel",       32'(pselSeen),  32'h0002);
        checkOutput("rd_hrdata",     HRDATA,         32'h1234_5678);
        checkOutput("rd_hresp",      32'(HRESP),     32'd0);
        checkOutput("rd_pwrite",     32'(PWRITE),    32'd0);
        checkOutput("rd_pwdata_hold", PWDATA,        32'hA5A5_0001);

        // Write answered with PSLVERR: LATCH, SETUP, ACCESS, ERR1 then ERR2
        runTransfer(1'b1, 32'h0F00_0020, 3'b010, 32'hDEAD_BEEF, 0, 1'b1, 32'h0);
        checkOutput("slverr_low_cycles", 32'(lowCycles), 32'd4);
        checkOutput("slverr_err1",       32'(errCycles), 32'd1);
        checkOutput("slverr_psel",       32'(pselSeen),  32'h8000);
        checkOutput("slverr_err2_hresp", 32'(HRESP),     32'd1);
        checkOutput("slverr_hrdata_hold", HRDATA,        32'h1234_5678);
        tick();
        checkOutput("slverr_idle_hresp",  32'(HRESP),     32'd0);
        checkOutput("slverr_idle_hready", 32'(HREADYOUT), 32'd1);

        // Read with PREADY stuck low: 4 ACCESS cycles then ERROR
        runTransfer(1'b0, 32'h0500_0000, 3'b010, 32'h0, 1000, 1'b0, 32'h0);
        checkOutput("tmo_low_cycles", 32'(lowCycles), 32'd6);
        checkOutput("tmo_acc_cycles", 32'(accCycles), 32'd4);
        checkOutput("tmo_err1",       32'(errCycles), 32'd1);
        checkOutput("tmo_psel_seen",  32'(pselSeen),  32'h0020);
        checkOutput("tmo_err2_psel",  32'(PSEL),      32'h0);
        checkOutput("tmo_err2_hresp", 32'(HRESP),     32'd1);
        checkOutput("tmo_hrdata_hold", HRDATA,        32'h1234_5678);
        tick();
        checkOutput("tmo_cancel_hresp", 32'(HRESP),     32'd0);
        checkOutput("tmo_cancel_psel",  32'(PSEL),      32'h0);

        // Byte write: rejected without any APB access
        runTransfer(1'b1, 32'h0200_0000, 3'b000, 32'h1111_2222, 0, 1'b0, 32'h0);
        checkOutput("byte_low_cycles",  32'(lowCycles), 32'd1);
        checkOutput("byte_err1",        32'(errCycles), 32'd1);
        checkOutput("byte_psel_seen",   32'(pselSeen),  32'h0);
        checkOutput("byte_err2_hresp",  32'(HRESP),     32'd1);
        checkOutput("byte_pwdata_hold", PWDATA,         32'hDEAD_BEEF);
        checkOutput("byte_paddr",       PADDR,          32'h0200_0000);
        tick();
        checkOutput("byte_idle_hresp",  32'(HRESP),     32'd0);

        // Back-to-back: read, then write presented in the read's completing cycle
        runTransfer(1'b0, 32'h0700_0008, 3'b010, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        checkOutput("b2b_rd_low_cycles", 32'(lowCycles), 32'd2);
        checkOutput("b2b_rd_hrdata",     HRDATA,         32'hCAFE_F00D);
        applyStimulus(1'b1, 32'h0900_000C, 3'b010);
        tick();
        endAddressPhase();
        HWDATA = 32'h1357_9BDF;
        checkOutput("b2b_latch_psel",    32'(PSEL),      32'h0);
        checkOutput("b2b_latch_hready",  32'(HREADYOUT), 32'd0);
        tick();
        checkOutput("b2b_setup_psel",    32'(PSEL),      32'h0200);
        checkOutput("b2b_setup_penable", 32'(PENABLE),   32'd0);
        checkOutput("b2b_setup_paddr",   PADDR,          32'h0900_000C);
        PREADY = 1'b0;
        tick();
        checkOutput("b2b_access_penable", 32'(PENABLE), 32'd1);
        checkOutput("b2b_access_pwdata",  PWDATA,       32'h1357_9BDF);
        checkOutput("b2b_access_pwrite",  32'(PWRITE),  32'd1);

        // Asynchronous reset in the middle of ACCESS
        #2;
        HRESET = 1'b1;
        #1;
        checkOutput("arst_psel",      32'(PSEL),      32'h0);
        checkOutput("arst_penable",   32'(PENABLE),   32'd0);
        checkOutput("arst_hreadyout", 32'(HREADYOUT), 32'd1);
        checkOutput("arst_hresp",     32'(HRESP),     32'd0);
        checkOutput("arst_hrdata",    HRDATA,         32'h0);
        checkOutput("arst_paddr",     PADDR,          32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        tick();

        // Normal read after reset, PSEL[10]
        runTransfer(1'b0, 32'h0A00_0000, 3'b010, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
        checkOutput("post_rd_low_cycles", 32'(lowCycles), 32'd2);
        checkOutput("post_rd_psel",       32'(pselSeen),  32'h0400);
        checkOutput("post_rd_hrdata",     HRDATA,         32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ahbl_apb_bridge.md
# ahbl_apb_bridge

AHB-Lite slave to APB3 master bridge. It sits directly downstream of the AHB-Lite bus functional model master in the UART verification environment. It converts each AHB-Lite single transfer into one APB3 SETUP/ACCESS sequence, so the APB UART and other APB peripherals can be driven from the AHB-Lite BFM. It adds wait states, decodes one of 16 PSEL lines, maps PSLVERR and PREADY timeouts onto the two-cycle AHB ERROR response, and rejects non-word writes.

## Interface
Parameters:
- SEL_LSB, 24: PSEL index is HADDR[SEL_LSB+3:SEL_LSB]. Legal range 2..28.
- TIMEOUT, 0: maximum ACCESS cycles allowed with PREADY low. 0 disables the timeout. Maximum value 65535.

Ports:
- HCLK  in  1  sole clock; everything is on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the AHB decoder.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type. Only NONSEQ/SEQ (HTRANS[1]=1) start a transfer.
- HWRITE  in  1  address-phase direction.
- HSIZE  in  3  transfer size. Only 3'b010 is legal for writes.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYIN  in  1  bus-level HREADY. It qualifies address-phase capture.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  registered read data.
- PADDR  out  32  APB address; equals the captured HADDR.
- PSEL  out  16  one-hot APB select.
- PENABLE  out  1  APB ACCESS-phase indicator.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

## Operation
- FSM states: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- Capture condition (`cap`) = HSEL & HTRANS[1] & HREADYIN & HREADYOUT. It is evaluated only in IDLE and ERR2. On `cap` the block registers HADDR, HWRITE, and the PSEL index.
- Transitions on `cap`:
  - HWRITE=1 and HSIZE≠3'b010 → ERR1. No APB access is made.
  - Otherwise, write → LATCH.
  - Otherwise, read → SETUP.
- Without `cap`: IDLE stays in IDLE; ERR2 goes to IDLE.
- Transfers with HTRANS IDLE or BUSY, or with HSEL=0, are ignored. The response is OKAY with zero wait states.
- LATCH: registers HWDATA into PWDATA. Next state SETUP.
- SETUP: PSEL[idx]=1, PENABLE=0. Next state ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. The timeout counter increments each cycle PREADY=0.
  - PREADY=1 & PSLVERR=0: HRDATA←PRDATA on reads only; next state IDLE.
  - PREADY=1 & PSLVERR=1: next state ERR1.
  - PREADY=0 and TIMEOUT≠0 and counter = TIMEOUT−1: next state ERR1.
- ERR1: HREADYOUT=0, HRESP=1. Next state ERR2.
- ERR2: HREADYOUT=1, HRESP=1.
- Output values by state:
  - HREADYOUT=1 only in IDLE and ERR2.
  - HRESP=1 only in ERR1 and ERR2.
  - PSEL and PENABLE are 0 outside SETUP and ACCESS.
- PADDR, PWRITE and PWDATA hold their values after the transfer until the next capture. HRDATA holds until the next read completes.
- The timeout counter is 16 bits and clears on entry to SETUP.

## Timing
- All outputs are registered. Reset values:
  - HREADYOUT=1; HRESP=0.
  - HRDATA, PADDR, PWDATA = 32'h0.
  - PSEL=16'h0; PENABLE=0; PWRITE=0.
  - State IDLE; counter 0.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronous). The in-flight transfer is abandoned and no AHB response is given.
- Write latency, with address phase in cycle T0 and PREADY=1 at first ACCESS: LATCH T1, SETUP T2, ACCESS T3, HREADYOUT=1 in T4. That is 3 wait states.
- Read latency: SETUP T1, ACCESS T2, HREADYOUT=1 with HRDATA valid in T3. That is 2 wait states.
- Each ACCESS cycle with PREADY=0 adds one wait state.
- Pipelined back-to-back transfers: a new address phase presented in the completing cycle (IDLE or ERR2) is captured in that same cycle. There are no dead cycles between APB transfers beyond LATCH.
- A master that drives HTRANS=IDLE in ERR2, cancelling after an error, starts nothing.
- Timeout: with TIMEOUT=N, ERR1 follows the Nth consecutive ACCESS cycle with PREADY=0. PSEL/PENABLE drop in ERR1.

## Test plan
- Reset, then write 32'hA5A5_0001 to HADDR 32'h0300_0010 (HSIZE=2, PREADY=1) → PSEL=16'h0008, PADDR=32'h0300_0010, PWDATA=32'hA5A5_0001, PWRITE=1. HREADYOUT is low for exactly 3 cycles, then HRESP=0.
- Read HADDR 32'h0100_0004 with PRDATA=32'h1234_5678 and PREADY low for 2 ACCESS cycles → PSEL=16'h0002. HREADYOUT is low for 4 cycles, then HRDATA=32'h1234_5678 with OKAY.
- Write with PREADY=1 and PSLVERR=1 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
- TIMEOUT=4, read with PREADY held 0 → exactly 4 ACCESS cycles, then PSEL=0 and the two-cycle ERROR response.
- Byte write (HSIZE=0) → PSEL stays 16'h0 throughout, and the two-cycle ERROR response is given.
- Back-to-back read then write, with the second address presented in the read's completing cycle → the second SETUP starts 2 cycles later (after LATCH). Then assert HRESET during ACCESS → PSEL=0, PENABLE=0, HREADYOUT=1 in the same cycle.
